boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Consumes the boot word stream produced by the BIOS block (a 32-bit word plus an active flag) and writes each word into instruction memory at consecutive addresses.
- When the stream ends, it asserts load_done and raises cu_enable to hand execution to the Control Unit.
- It is the receiving end of the BIOS→memory path and sits between the BIOS, instruction memory and the Control Unit.

Parameters:
- DATA_WIDTH, 32, width of a boot word / memory word
- ADDR_WIDTH, 8, instruction memory address width; capacity DEPTH = 2**ADDR_WIDTH words
- START_ADDR, 0, first memory address written

Ports:
- clock  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- bios_data  input  DATA_WIDTH  word presented by BIOS
- bios_active  input  1  high = bios_data valid this cycle; falling = end of stream
- mem_we  output  1  instruction memory write enable
- mem_addr  output  ADDR_WIDTH  instruction memory write address
- mem_wdata  output  DATA_WIDTH  instruction memory write data
- word_count  output  ADDR_WIDTH+1  number of words written so far
- load_done  output  1  stream ended cleanly, memory image complete
- overflow  output  1  stream exceeded DEPTH words
- cu_enable  output  1  Control Unit may start fetching

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0.
  - mem_addr=START_ADDR, state IDLE, internal address=START_ADDR, count=0.
  - Reset mid-load discards progress; memory contents are not cleared.
- States: IDLE, LOAD, DONE, ERROR. All outputs are registered.
- IDLE:
  - Waits for bios_active=1. mem_we=0.
  - On the first edge with bios_active=1, the word is captured as in LOAD (no lost first word) and the state goes to LOAD.
- LOAD:
  - Each rising edge with bios_active=1 and count<DEPTH: mem_we=1, mem_addr=addr, mem_wdata=bios_data, then addr+1 and count+1 (one-cycle latency, sample to write).
  - Address wraps modulo DEPTH; this only matters when START_ADDR≠0.
  - Edge with bios_active=0: mem_we=0, go to DONE. The word on bios_data in that cycle is ignored.
  - Edge with bios_active=1 and count==DEPTH: mem_we=0, overflow=1, go to ERROR. No write occurs.
- DONE:
  - load_done=1 on entry.
  - cu_enable=1 one cycle after load_done, so memory's last write has settled.
  - Both hold until reset; bios_active re-asserting is ignored.
- ERROR:
  - overflow=1, load_done=0, cu_enable=0, mem_we=0.
  - All input ignored until reset.
- Simultaneous events: bios_active falling on the same edge count reaches DEPTH counts as a clean end (DONE, not ERROR).
- Single-word stream: bios_active high for one cycle gives one write at START_ADDR, word_count=1, then DONE.
- word_count is stable and valid in DONE/ERROR.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- When defined:
  - Extra output port checksum, DATA_WIDTH, reset 0.
  - Accumulates a modulo-2**DATA_WIDTH sum of every word actually written (not ignored or overflow words).
  - The sum is updated on the same edge as the write and frozen in DONE/ERROR.
- When undefined: port and adder are absent; all other behaviour is identical.

Test Plan:
- Stream 0x00000013, 0x00100093, 0x00208113 (bios_active high 3 cycles, then low) → writes at addr 0,1,2 with matching data, one cycle after each sample. word_count=3, load_done=1 the cycle after active falls, cu_enable=1 one cycle later; with BOOT_LOADER_CHECKSUM_EN, checksum=0x003081B9.
- ADDR_WIDTH=2, stream of 5 words → 4 writes (addr 0..3), 5th edge sets overflow=1. load_done and cu_enable stay 0, mem_we stays 0 afterwards.
- ADDR_WIDTH=2, exactly 4 words, active falls on the edge after the 4th → DONE, overflow=0, word_count=4.
- Drop reset_n mid-stream after 2 words, release with bios_active=1 → outputs 0 immediately. Reload restarts at START_ADDR and word_count counts from 0.
- bios_active high 1 cycle with data 0xDEADBEEF, START_ADDR=3 → single write addr 3. After DONE, re-raise bios_active with 0x12345678 → no write, word_count stays 1.
- Hold bios_active=0 for 20 cycles after reset → stays IDLE, all outputs 0, no write.

Source files
------------

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - writes the BIOS boot word stream into instruction memory, then enables the Control Unit (optional checksum output: BOOT_LOADER_CHECKSUM_EN)
module boot_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int START_ADDR = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] bios_data,
  input  logic                  bios_active,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  load_done,
  output logic                  overflow,
  output logic                  cu_enable
`ifdef BOOT_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] START_C = ADDR_WIDTH'(START_ADDR);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  write;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic                  load_done_d;
  logic                  overflow_d;
  logic                  cu_enable_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_d;
`endif

  // Next state and next registered outputs; every write path goes through 'write'
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    write       = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    load_done_d = load_done;
    overflow_d  = overflow;
    cu_enable_d = cu_enable;
`ifdef BOOT_LOADER_CHECKSUM_EN
    checksum_d  = checksum;
`endif
    case (state_q)
      IDLE: begin
        // The first active cycle is already a data word
        if (bios_active) begin
          write   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!bios_active) begin
          load_done_d = 1'b1;
          state_d     = DONE;
        end else if (count_q == DEPTH_C) begin
          overflow_d = 1'b1;
          state_d    = ERROR;
        end else begin
          write = 1'b1;
        end
      end
      DONE: begin
        // One cycle behind load_done so the last memory write has settled
        cu_enable_d = 1'b1;
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: state_d = IDLE;
    endcase

    if (write) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = addr_q;
      mem_wdata_d = bios_data;
      addr_d      = addr_q + 1'b1;
      count_d     = count_q + 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
      checksum_d  = checksum + bios_data;
`endif
    end
  end

  // State, address/count and all outputs are registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= START_C;
      count_q    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= START_C;
      mem_wdata  <= '0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
      cu_enable  <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      load_done  <= load_done_d;
      overflow   <= overflow_d;
      cu_enable  <= cu_enable_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
      checksum   <= checksum_d;
`endif
    end
  end

  assign word_count = count_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - scoreboard bench for boot_loader over three parameter sets
module tb_boot_loader;

  localparam int N = 3;
  localparam int AWS [N] = '{8, 2, 2};
  localparam int SAS [N] = '{0, 0, 3};

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] bios_data;
  logic        bios_active;

  logic        m_we    [N];
  logic [7:0]  m_addr  [N];
  logic [31:0] m_wdata [N];
  logic [8:0]  m_cnt   [N];
  logic        m_done  [N];
  logic        m_ovf   [N];
  logic        m_cu    [N];
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] m_sum   [N];
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int AW    = AWS[g];
    localparam int SA    = SAS[g];
    localparam int DEPTH = 1 << AW;

    logic [AW-1:0] addr;
    logic [AW:0]   cnt;

    boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .START_ADDR(SA)) u_dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .bios_data   (bios_data),
      .bios_active (bios_active),
      .mem_we      (m_we[g]),
      .mem_addr    (addr),
      .mem_wdata   (m_wdata[g]),
      .word_count  (cnt),
      .load_done   (m_done[g]),
      .overflow    (m_ovf[g]),
      .cu_enable   (m_cu[g])
`ifdef BOOT_LOADER_CHECKSUM_EN
      ,
      .checksum    (m_sum[g])
`endif
    );

    assign m_addr[g] = 8'(addr);
    assign m_cnt[g]  = 9'(cnt);

    // Reference model: a stream is a run of accepted words; it ends on the first
    // inactive cycle after at least one word, or faults on a word beyond capacity.
    wr_t         q[$];
    int          written;
    bit          ended;
    bit          ovf;
    int          done_edges;
    logic [31:0] sum;
    wr_t         e;

    initial begin
      written = 0; ended = 0; ovf = 0; done_edges = 0; sum = 0;
      forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
          written = 0; ended = 0; ovf = 0; done_edges = 0; sum = 0;
          q.delete();
        end else begin
          if (ended) done_edges++;
          if (!ended && !ovf) begin
            if (bios_active) begin
              if (written < DEPTH) begin
                q.push_back(wr_t'{8'((SA + written) % DEPTH), bios_data});
                sum = sum + bios_data;
                written++;
              end else begin
                ovf = 1;
              end
            end else if (written > 0) begin
              ended = 1;
            end
          end
        end
      end
    end

    // Monitor: every write the DUT presents must match the head of the queue
    initial begin
      forever begin
        @(negedge clock);
        if (reset_n) begin
          if (m_we[g]) begin
            tests++;
            if (q.size() == 0) begin
              fails++;
              $display("FAIL dut%0d unexpected_write got addr=%0h data=%0h required no write",
                       g, m_addr[g], m_wdata[g]);
            end else begin
              e = q.pop_front();
              if (m_addr[g] !== e.addr || m_wdata[g] !== e.data) begin
                fails++;
                $display("FAIL dut%0d write got addr=%0h data=%0h required addr=%0h data=%0h",
                         g, m_addr[g], m_wdata[g], e.addr, e.data);
              end
            end
          end else if (q.size() != 0) begin
            tests++;
            fails++;
            e = q.pop_front();
            $display("FAIL dut%0d missing_write got none required addr=%0h data=%0h",
                     g, e.addr, e.data);
          end
          tests++;
          if ({m_done[g], m_cu[g], m_ovf[g], m_cnt[g]} !==
              {ended, (ended && done_edges >= 1), ovf, 9'(written)}) begin
            fails++;
            $display("FAIL dut%0d status got done=%0b cu=%0b ovf=%0b count=%0d required done=%0b cu=%0b ovf=%0b count=%0d",
                     g, m_done[g], m_cu[g], m_ovf[g], m_cnt[g],
                     ended, (ended && done_edges >= 1), ovf, written);
          end
`ifdef BOOT_LOADER_CHECKSUM_EN
          tests++;
          if (m_sum[g] !== sum) begin
            fails++;
            $display("FAIL dut%0d checksum got %0h required %0h", g, m_sum[g], sum);
          end
`endif
        end
      end
    end
  end

  task automatic drive(input bit a, input logic [31:0] d);
    @(negedge clock);
    #1;
    bios_active = a;
    bios_data   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom);
  endtask

  task automatic words(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, $urandom);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge
  task automatic do_reset();
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      tests++;
      if (m_we[i] !== 1'b0 || m_addr[i] !== 8'(SAS[i]) || m_wdata[i] !== 32'h0 ||
          m_cnt[i] !== 9'h0 || m_done[i] !== 1'b0 || m_ovf[i] !== 1'b0 || m_cu[i] !== 1'b0) begin
        fails++;
        $display("FAIL dut%0d reset got we=%0b addr=%0h wdata=%0h count=%0d done=%0b ovf=%0b cu=%0b required all zero, addr=%0h",
                 i, m_we[i], m_addr[i], m_wdata[i], m_cnt[i], m_done[i], m_ovf[i], m_cu[i], SAS[i]);
      end
    end
    @(negedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    bios_active = 1'b0;
    bios_data   = '0;
    do_reset();

    // Long idle after reset: nothing happens
    idle(20);

    // Three-instruction image
    drive(1'b1, 32'h00000013);
    drive(1'b1, 32'h00100093);
    drive(1'b1, 32'h00208113);
    idle(4);
`ifdef BOOT_LOADER_CHECKSUM_EN
    tests++;
    if (m_sum[0] !== 32'h003081B9) begin
      fails++;
      $display("FAIL image_checksum got %0h required 003081b9", m_sum[0]);
    end
`endif
    do_reset();

    // Five words: overflow on the four-word instances, followed by ignored activity
    words(5);
    idle(3);
    words(2);
    idle(2);
    do_reset();

    // Exactly capacity on the four-word instances
    words(4);
    idle(3);
    do_reset();

    // Reset mid-stream, released while the stream is still active
    words(2);
    do_reset();
    words(3);
    idle(3);
    do_reset();

    // Single-word stream, then a re-raise that must be ignored
    drive(1'b1, 32'hDEADBEEF);
    idle(3);
    drive(1'b1, 32'h12345678);
    drive(1'b1, 32'h12345678);
    idle(2);
    do_reset();

    // Randomised streams
    for (int it = 0; it < 30; it++) begin
      idle($urandom_range(0, 3));
      words($urandom_range(0, 6));
      idle($urandom_range(1, 3));
      words($urandom_range(0, 2));
      idle(1);
      do_reset();
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
